// File: rtl/csi_slave_protocol_layer_if.sv
// Byte-stream input and camera-style pixel output of the CSI-2 receive protocol layer.
// slave: the protocol layer itself; master: the byte source / pixel sink side.
interface csi_slave_protocol_layer_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        vsync;
    logic        hsync;
    logic        data_valid;
    logic [13:0] data;
    logic [15:0] frame_num;
    logic        err_wc;
    logic        err_dt;
    logic        err_frame;
    logic        err_ecc;

    modport slave (
        input  in_valid, in_data,
        output vsync, hsync, data_valid, data, frame_num,
        output err_wc, err_dt, err_frame, err_ecc
    );

    modport master (
        output in_valid, in_data,
        input  vsync, hsync, data_valid, data, frame_num,
        input  err_wc, err_dt, err_frame, err_ecc
    );
endinterface

// File: rtl/csi_slave_protocol_layer.sv
// CSI-2 receive protocol layer: parses FS/FE short packets and RAW14 long packets into 14-bit pixels.
// Optional header ECC byte check is enabled by defining CSI_SLAVE_ECC_CHECK_EN.
//
// state      | meaning
// ST_HDR     | collecting the 4 header bytes, decode on byte 3
// ST_PAYLOAD | consuming RAW14 payload in 7-byte groups
// ST_SKIP    | discarding the word count of a rejected long packet
module csi_slave_protocol_layer #(
    parameter int         IMAGE_LINES           = 4,
    parameter int         IMAGE_LINE_PIXELS     = 8,
    parameter logic [1:0] VIRTUAL_CHANNEL       = 2'd0,
    parameter logic [7:0] ECC                   = 8'h00,
    parameter logic [5:0] FRAME_START_DATA_TYPE = 6'h00,
    parameter logic [5:0] FRAME_END_DATA_TYPE   = 6'h01,
    parameter logic [5:0] PIXEL14BITS_DATA_TYPE = 6'h2D
) (
    input  logic                       clk,
    input  logic                       rst,
    csi_slave_protocol_layer_if.slave  bus
);

    localparam int PAYLOAD_WC = IMAGE_LINES * (IMAGE_LINE_PIXELS / 4) * 7;
    localparam int PIX_W      = (IMAGE_LINE_PIXELS > 1) ? $clog2(IMAGE_LINE_PIXELS) : 1;
    localparam int LINE_W     = $clog2(IMAGE_LINES + 1);

    localparam logic [PIX_W-1:0]  PIX_LAST     = PIX_W'(IMAGE_LINE_PIXELS - 1);
    localparam logic [LINE_W-1:0] LINE_FULL    = LINE_W'(IMAGE_LINES);
    localparam logic [15:0]       PAYLOAD_WC16 = 16'(PAYLOAD_WC);

    typedef enum logic [1:0] {
        ST_HDR,
        ST_PAYLOAD,
        ST_SKIP
    } state_t;

    state_t            state;
    logic [1:0]        hdr_idx;
    logic [7:0]        hdr_b0;
    logic [7:0]        hdr_b1;
    logic [7:0]        hdr_b2;
    logic [15:0]       byte_cnt;
    logic [2:0]        grp_idx;
    logic [23:0]       grp_tail;
    logic [7:0]        grp_msb [3];
    logic [13:0]       emit_pix [4];
    logic [1:0]        emit_idx;
    logic              emit_busy;
    logic [PIX_W-1:0]  pix_cnt;
    logic [LINE_W-1:0] line_cnt;

    logic        vsync_q;
    logic        hsync_q;
    logic        dv_q;
    logic [13:0] data_q;
    logic [15:0] frame_num_q;
    logic        err_wc_q;
    logic        err_dt_q;
    logic        err_frame_q;
    logic        err_ecc_q;

    logic [1:0]  hdr_vc;
    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic        hdr_long;
    logic        hdr_vc_ok;
    logic        grp_done;
    logic        emit_now;
    logic        ecc_ok;
    logic [13:0] new_pix [4];
    logic [13:0] pix_out;

    assign hdr_vc    = hdr_b0[7:6];
    assign hdr_dt    = hdr_b0[5:0];
    assign hdr_wc    = {hdr_b2, hdr_b1};
    assign hdr_long  = (hdr_dt >= 6'h10);
    assign hdr_vc_ok = (hdr_vc == VIRTUAL_CHANNEL);

`ifdef CSI_SLAVE_ECC_CHECK_EN
    assign ecc_ok = (bus.in_data == ECC);
`else
    logic unused_ecc;
    assign unused_ecc = ^ECC;
    assign ecc_ok     = 1'b1;
`endif

    // Pixel 3's MSB byte is the 7th group byte, still on the input when the group completes.
    assign grp_done   = bus.in_valid && (state == ST_PAYLOAD) && (grp_idx == 3'd6);
    assign new_pix[0] = {grp_msb[0], grp_tail[5:0]};
    assign new_pix[1] = {grp_msb[1], grp_tail[11:6]};
    assign new_pix[2] = {grp_msb[2], grp_tail[17:12]};
    assign new_pix[3] = {bus.in_data, grp_tail[23:18]};

    assign emit_now = grp_done || emit_busy;
    assign pix_out  = grp_done ? new_pix[0] : emit_pix[emit_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_HDR;
            hdr_idx     <= 2'd0;
            hdr_b0      <= 8'd0;
            hdr_b1      <= 8'd0;
            hdr_b2      <= 8'd0;
            byte_cnt    <= 16'd0;
            grp_idx     <= 3'd0;
            grp_tail    <= 24'd0;
            for (int i = 0; i < 3; i++) grp_msb[i] <= 8'd0;
            for (int i = 0; i < 4; i++) emit_pix[i] <= 14'd0;
            emit_idx    <= 2'd0;
            emit_busy   <= 1'b0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            vsync_q     <= 1'b0;
            hsync_q     <= 1'b0;
            dv_q        <= 1'b0;
            data_q      <= 14'd0;
            frame_num_q <= 16'd0;
            err_wc_q    <= 1'b0;
            err_dt_q    <= 1'b0;
            err_frame_q <= 1'b0;
            err_ecc_q   <= 1'b0;
        end else begin
            err_wc_q    <= 1'b0;
            err_dt_q    <= 1'b0;
            err_frame_q <= 1'b0;
            err_ecc_q   <= 1'b0;

            if (grp_done) begin
                for (int i = 0; i < 4; i++) emit_pix[i] <= new_pix[i];
                emit_idx  <= 2'd1;
                emit_busy <= 1'b1;
            end else if (emit_busy) begin
                emit_idx <= emit_idx + 2'd1;
                if (emit_idx == 2'd3) emit_busy <= 1'b0;
            end

            // HSync holds through gaps between groups of the same line, drops only at line end.
            if (emit_now) begin
                dv_q    <= 1'b1;
                data_q  <= pix_out;
                hsync_q <= 1'b1;
                if (pix_cnt == PIX_LAST) begin
                    pix_cnt <= '0;
                    if (line_cnt != LINE_FULL) line_cnt <= line_cnt + 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end else begin
                dv_q    <= 1'b0;
                hsync_q <= (pix_cnt != '0);
            end

            if (bus.in_valid) begin
                case (state)
                    ST_HDR: begin
                        hdr_idx <= hdr_idx + 2'd1;
                        case (hdr_idx)
                            2'd0:    hdr_b0 <= bus.in_data;
                            2'd1:    hdr_b1 <= bus.in_data;
                            2'd2:    hdr_b2 <= bus.in_data;
                            default: ;
                        endcase
                        if (hdr_idx == 2'd3) begin
                            if (!ecc_ok) begin
                                err_ecc_q <= 1'b1;
                                if (hdr_long && (hdr_wc != 16'd0)) begin
                                    state    <= ST_SKIP;
                                    byte_cnt <= hdr_wc;
                                end
                            end else if (hdr_vc_ok && (hdr_dt == FRAME_START_DATA_TYPE)) begin
                                frame_num_q <= hdr_wc;
                                err_frame_q <= vsync_q;
                                vsync_q     <= 1'b1;
                                pix_cnt     <= '0;
                                line_cnt    <= '0;
                            end else if (hdr_vc_ok && (hdr_dt == FRAME_END_DATA_TYPE)) begin
                                vsync_q     <= 1'b0;
                                err_frame_q <= !vsync_q || (hdr_wc != frame_num_q) ||
                                               (line_cnt < LINE_FULL);
                            end else if (hdr_vc_ok && (hdr_dt == PIXEL14BITS_DATA_TYPE)) begin
                                if (hdr_wc == PAYLOAD_WC16) begin
                                    state       <= ST_PAYLOAD;
                                    byte_cnt    <= hdr_wc;
                                    grp_idx     <= 3'd0;
                                    err_frame_q <= !vsync_q;
                                end else begin
                                    err_wc_q <= 1'b1;
                                    if (hdr_wc != 16'd0) begin
                                        state    <= ST_SKIP;
                                        byte_cnt <= hdr_wc;
                                    end
                                end
                            end else begin
                                err_dt_q <= 1'b1;
                                if (hdr_long && (hdr_wc != 16'd0)) begin
                                    state    <= ST_SKIP;
                                    byte_cnt <= hdr_wc;
                                end
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        case (grp_idx)
                            3'd0:    grp_tail[7:0]   <= bus.in_data;
                            3'd1:    grp_tail[15:8]  <= bus.in_data;
                            3'd2:    grp_tail[23:16] <= bus.in_data;
                            3'd3:    grp_msb[0]      <= bus.in_data;
                            3'd4:    grp_msb[1]      <= bus.in_data;
                            3'd5:    grp_msb[2]      <= bus.in_data;
                            default: ;
                        endcase
                        grp_idx  <= (grp_idx == 3'd6) ? 3'd0 : grp_idx + 3'd1;
                        byte_cnt <= byte_cnt - 16'd1;
                        if (byte_cnt == 16'd1) state <= ST_HDR;
                    end
                    ST_SKIP: begin
                        byte_cnt <= byte_cnt - 16'd1;
                        if (byte_cnt == 16'd1) state <= ST_HDR;
                    end
                    default: state <= ST_HDR;
                endcase
            end
        end
    end

    assign bus.vsync      = vsync_q;
    assign bus.hsync      = hsync_q;
    assign bus.data_valid = dv_q;
    assign bus.data       = data_q;
    assign bus.frame_num  = frame_num_q;
    assign bus.err_wc     = err_wc_q;
    assign bus.err_dt     = err_dt_q;
    assign bus.err_frame  = err_frame_q;
    assign bus.err_ecc    = err_ecc_q;

endmodule

// File: tb/tb_csi_slave_protocol_layer.sv
// Directed bench for csi_slave_protocol_layer: pixel scoreboard plus error-pulse counters.
// Covers both builds of CSI_SLAVE_ECC_CHECK_EN.
module tb_csi_slave_protocol_layer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    csi_slave_protocol_layer_if bus ();

    csi_slave_protocol_layer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [13:0] exp_q [$];

    int n_wc = 0, n_dt = 0, n_frame = 0, n_ecc = 0, n_pix = 0;
    int hs_windows = 0, hs_pix = 0;
    int e_wc = 0, e_dt = 0, e_frame = 0, e_ecc = 0;
    logic prev_hs = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: counts error pulses and pops the pixel scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hs = 1'b0;
                hs_pix  = 0;
            end else begin
                if (bus.err_wc)    n_wc++;
                if (bus.err_dt)    n_dt++;
                if (bus.err_frame) n_frame++;
                if (bus.err_ecc)   n_ecc++;
                if (bus.data_valid) begin
                    n_pix++;
                    hs_pix++;
                    check("hsync_during_pixel", 32'(bus.hsync), 32'd1);
                    check("pixel_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("pixel_data", 32'(bus.data), 32'(exp_q.pop_front()));
                end
                if (!bus.hsync && prev_hs) begin
                    check("pixels_per_line", hs_pix, 8);
                    hs_pix = 0;
                end
                if (bus.hsync && !prev_hs) hs_windows++;
                prev_hs = bus.hsync;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic send_group(input logic [55:0] g, input bit gap);
        logic [23:0] tail;
        tail = g[23:0];
        for (int k = 0; k < 4; k++) exp_q.push_back({g[8*(3+k) +: 8], 6'((tail >> (6*k)) & 24'h3F)});
        for (int i = 0; i < 7; i++) begin
            send_byte(g[8*i +: 8]);
            if (gap && i == 2) idle(3);
        end
    endtask

    task automatic send_payload(input logic [55:0] g0, input logic [55:0] g1);
        send_hdr(8'h2D, 8'h38, 8'h00, 8'h00);
        send_group(g0, 1'b0);
        check("dv_latency", 32'(bus.data_valid), 32'd1);
        check("first_pixel", 32'(bus.data), 32'({g0[31:24], g0[5:0]}));
        send_group(g1, 1'b1);
        for (int j = 0; j < 6; j++) send_group(56'({$urandom(), $urandom()}), 1'b0);
    endtask

    task automatic check_errs();
        check("err_wc_count", n_wc, e_wc);
        check("err_dt_count", n_dt, e_dt);
        check("err_frame_count", n_frame, e_frame);
        check("err_ecc_count", n_ecc, e_ecc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs_before;
        int pix_before;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_vsync", 32'(bus.vsync), 32'd0);
        check("rst_hsync", 32'(bus.hsync), 32'd0);
        check("rst_dv", 32'(bus.data_valid), 32'd0);
        check("rst_data", 32'(bus.data), 32'd0);
        check("rst_frame_num", 32'(bus.frame_num), 32'd0);
        check("rst_errs", 32'({bus.err_wc, bus.err_dt, bus.err_frame, bus.err_ecc}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Frame Start, frame 5
        send_hdr(8'h00, 8'h05, 8'h00, 8'h00);
        check("fs_vsync_next_cycle", 32'(bus.vsync), 32'd1);
        check("fs_frame_num", 32'(bus.frame_num), 32'h5);
        settle();
        check_errs();

        // Full frame: all-FF group, the 01..80 group with an input gap, then random groups; FE follows at once
        hs_before  = hs_windows;
        pix_before = n_pix;
        send_payload(56'hFF_FF_FF_FF_FF_FF_FF, 56'h80_00_00_00_00_00_01);
        send_hdr(8'h01, 8'h05, 8'h00, 8'h00);
        check("fe_vsync_next_cycle", 32'(bus.vsync), 32'd0);
        settle();
        check_errs();
        check("frame_queue_drained", exp_q.size(), 0);
        check("frame_hsync_windows", hs_windows - hs_before, 4);
        check("frame_pixel_count", n_pix - pix_before, 32);

        // Wrong word count: ErrWc, 16 bytes skipped, next FS parsed
        pix_before = n_pix;
        send_hdr(8'h2D, 8'h10, 8'h00, 8'h00);
        e_wc++;
        for (int i = 0; i < 16; i++) send_byte(8'hFF);
        send_hdr(8'h00, 8'h05, 8'h00, 8'h00);
        check("skip_then_fs_vsync", 32'(bus.vsync), 32'd1);
        check("skip_then_fs_frame_num", 32'(bus.frame_num), 32'h5);
        settle();
        check("skip_no_pixels", n_pix - pix_before, 0);
        check_errs();

        // Complete frame closed by FE carrying the wrong frame number
        send_payload(56'({$urandom(), $urandom()}), 56'({$urandom(), $urandom()}));
        send_hdr(8'h01, 8'h06, 8'h00, 8'h00);
        e_frame++;
        check("fe_mismatch_vsync", 32'(bus.vsync), 32'd0);
        settle();
        check_errs();
        check("mismatch_queue_drained", exp_q.size(), 0);

        // Second FS while VSync is high, then an FE with no lines emitted
        send_hdr(8'h00, 8'h07, 8'h00, 8'h00);
        send_hdr(8'h00, 8'h08, 8'h00, 8'h00);
        e_frame++;
        settle();
        check("double_fs_vsync", 32'(bus.vsync), 32'd1);
        check("double_fs_frame_num", 32'(bus.frame_num), 32'h8);
        check_errs();
        send_hdr(8'h01, 8'h08, 8'h00, 8'h00);
        e_frame++;
        settle();
        check("short_frame_vsync", 32'(bus.vsync), 32'd0);
        check_errs();

        // Unknown short DT, unknown long DT with skip, and FS on a foreign VC
        send_hdr(8'h05, 8'h00, 8'h00, 8'h00);
        e_dt++;
        send_hdr(8'h12, 8'h03, 8'h00, 8'h00);
        e_dt++;
        send_byte(8'hAA);
        send_byte(8'hAA);
        send_byte(8'hAA);
        send_hdr(8'h40, 8'h05, 8'h00, 8'h00);
        e_dt++;
        settle();
        check("foreign_vc_vsync", 32'(bus.vsync), 32'd0);
        check("foreign_vc_frame_num", 32'(bus.frame_num), 32'h8);
        check_errs();

        // Payload outside a frame: pixels still emitted, one ErrFrame
        hs_before  = hs_windows;
        pix_before = n_pix;
        send_payload(56'({$urandom(), $urandom()}), 56'({$urandom(), $urandom()}));
        e_frame++;
        repeat (6) settle();
        check_errs();
        check("orphan_queue_drained", exp_q.size(), 0);
        check("orphan_hsync_windows", hs_windows - hs_before, 4);
        check("orphan_pixel_count", n_pix - pix_before, 32);

        // Reset while a group is being emitted
        send_hdr(8'h00, 8'h09, 8'h00, 8'h00);
        send_hdr(8'h2D, 8'h38, 8'h00, 8'h00);
        send_group(56'h12_34_56_78_9A_BC_DE, 1'b0);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("pre_reset_dv", 32'(bus.data_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_dv", 32'(bus.data_valid), 32'd0);
        check("midrst_vsync", 32'(bus.vsync), 32'd0);
        check("midrst_hsync", 32'(bus.hsync), 32'd0);
        check("midrst_data", 32'(bus.data), 32'd0);
        check("midrst_frame_num", 32'(bus.frame_num), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_hdr(8'h00, 8'h09, 8'h00, 8'h00);
        settle();
        check("post_rst_fs_vsync", 32'(bus.vsync), 32'd1);
        check("post_rst_fs_frame_num", 32'(bus.frame_num), 32'h9);
        check_errs();
        send_hdr(8'h01, 8'h09, 8'h00, 8'h00);
        e_frame++;
        settle();
        check_errs();

        // FS with a corrupted ECC byte
        send_hdr(8'h00, 8'h0A, 8'h00, 8'hFF);
        settle();
`ifdef CSI_SLAVE_ECC_CHECK_EN
        e_ecc++;
        check("ecc_bad_vsync", 32'(bus.vsync), 32'd0);
        check("ecc_bad_frame_num", 32'(bus.frame_num), 32'h9);
`else
        check("ecc_ignored_vsync", 32'(bus.vsync), 32'd1);
        check("ecc_ignored_frame_num", 32'(bus.frame_num), 32'hA);
`endif
        check_errs();
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csi_slave_protocol_layer.md
# csi_slave_protocol_layer

Receive-side MIPI CSI-2 protocol layer. Consumes the byte stream delivered by the D-PHY receiver's byte FIFO, parses Frame Start / Frame End short packets and the RAW14 long packet, and unpacks every 7 payload bytes into four 14-bit pixels. It regenerates a camera-style interface (VSync, HSync, Data) for the image sink or scoreboard. It is the inverse of the master protocol layer and sits between the D-PHY RX byte output and the pixel consumer.

## Interface
- IMAGE_LINES, 4, lines per frame.
- IMAGE_LINE_PIXELS, 8, pixels per line; multiple of 4.
- VIRTUAL_CHANNEL, 2'd0, accepted VC; a header with any other VC is treated as unknown DT.
- ECC, 8'h00, fixed header ECC byte value.
- FRAME_START_DATA_TYPE / FRAME_END_DATA_TYPE / PIXEL14BITS_DATA_TYPE, 6'h00 / 6'h01 / 6'h2D.
- Clk  input  1  single clock.
- Rst  input  1  asynchronous, active-high reset.
- InValid  input  1  InData valid this cycle; every valid byte is consumed, no back-pressure.
- InData  input  8  received byte, wire order.
- VSync  output  1  high from Frame Start until Frame End.
- HSync  output  1  high from the first through the last pixel of a line.
- DataValid  output  1  Data carries a pixel this cycle.
- Data  output  14  pixel value.
- FrameNum  output  16  frame number latched from the Frame Start packet.
- ErrWc, ErrDt, ErrFrame, ErrEcc  output  1 each  single-cycle error pulses.

## Operation
- Header: 4 bytes, LSB first. Byte0 = {VC[1:0], DT[5:0]}, byte1/byte2 = WC or frame number low/high, byte3 = ECC.
- FSM states:
  - HDR: collect 4 header bytes, then decode.
  - PAYLOAD: consume WC bytes.
  - SKIP: discard WC bytes.
- Decode:
  - FS: latch FrameNum, set VSync, clear line/pixel counters. Pulse ErrFrame if VSync is already high; VSync stays high and FrameNum is updated.
  - FE: clear VSync. Pulse ErrFrame if VSync was low, or if the frame number differs from FrameNum, or if fewer than IMAGE_LINES lines were emitted.
  - RAW14 with WC = IMAGE_LINES*(IMAGE_LINE_PIXELS/4)*7: enter PAYLOAD.
  - RAW14 with any other WC: pulse ErrWc, enter SKIP for WC bytes.
  - Other long DT (DT ≥ 6'h10): pulse ErrDt, enter SKIP.
  - Other short DT (DT < 6'h10): pulse ErrDt, ignore, stay in HDR.
  - WC = 0 in SKIP: return to HDR immediately.
- Payload group of 7 bytes:
  - Bytes 0–2 form a 24-bit tail word, LSB first. Tail of pixel k = bits [6k+5:6k].
  - Bytes 3–6 carry MSBs [13:6] of pixels 0–3.
  - Pixel k = {byte(3+k), tail_k}.
- On the 7th byte, the group is copied into an emit register. The emitter drives pixels 0..3 on 4 consecutive cycles, so collection of the next group overlaps emission.
- Pixel counter wraps at IMAGE_LINE_PIXELS and increments the line counter.
- If RAW14 payload arrives with VSync low, pixels are still emitted and ErrFrame pulses once.

## Timing
- Reset values: VSync, HSync, DataValid, all Err* = 0; Data = 0; FrameNum = 0; FSM = HDR; all counters = 0.
- FS/FE: header byte3 accepted at cycle N -> VSync changes at N+1; error pulses also at N+1.
- Payload: 7th group byte at cycle N -> DataValid at N+1..N+4, pixels 0..3 in order.
- FE byte3 arrives at N+4 at the earliest, so VSync falls at N+5, after the last pixel.
- HSync:
  - rises with DataValid of pixel 0 of a line;
  - falls the cycle after the last pixel of the line;
  - is low during inter-group gaps only at line boundaries.
- InValid gaps stall parsing only. Emission is never stalled.
- Rst asserted mid-packet clears all state asynchronously. The first byte after release is parsed as header byte0.

## Configuration
- CSI_SLAVE_ECC_CHECK_EN defined:
  - header byte3 is compared to ECC;
  - on mismatch, ErrEcc pulses at N+1, the packet is dropped, a long packet's WC bytes are skipped, and VSync/FrameNum are unchanged.
- Undefined: byte3 is ignored and ErrEcc is tied to 0.

## Test plan
- FS bytes 00,05,00,00 -> VSync=1 at byte3+1, FrameNum=16'h0005, no error.
- Long header 2D,38,00,00 (WC=56) then 7 bytes all FF -> four DataValid cycles with Data=14'h3FFF; HSync high for pixels 0–3.
- Group 01,00,00,00,00,00,80 -> Data 14'h0001, 0, 0, 14'h2000. A full 4x8 frame gives 4 HSync windows of 8 pixels each; FE 01,05,00,00 -> VSync=0, no error.
- Long header 2D,10,00,00 (WC=16) -> ErrWc pulse, 16 bytes skipped, no DataValid, next FS parsed correctly.
- FE with frame number 6 after FS 5 -> ErrFrame pulse, VSync=0. A second FS while VSync is high -> ErrFrame.
- Rst mid-payload (after byte 3 of a group) -> all outputs 0 immediately. With CSI_SLAVE_ECC_CHECK_EN: FS with byte3=FF -> ErrEcc, VSync stays 0.
